// File: rtl/load_store_unit.sv
// Load/store unit: drives the byte-addressed data memory port and splits
// misaligned halfword/word accesses into byte accesses.
module load_store_unit #(
   parameter int MEM_BYTES      = 1024,
   parameter bit MISALIGN_SPLIT = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic [2:0]  mem_funct3,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [2:0] {IDLE, ACCESS, SPLIT, RESP, ERR} state_t;

   state_t      state, state_nx;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q, wdata_q, data_q;
   logic [1:0]  idx_q, last_q;
   logic [2:0]  size_in;
   logic [32:0] end_addr;
   logic        legal, range_bad, misal;
   logic [7:0]  wbyte;

   always_comb begin
      size_in = 3'd4;
      unique case (req_funct3[1:0])
         2'b00:   size_in = 3'd1;
         2'b01:   size_in = 3'd2;
         default: size_in = 3'd4;
      endcase
      end_addr  = {1'b0, req_addr} + {30'b0, size_in};
      range_bad = end_addr > 33'(MEM_BYTES);
      if (req_we)
         legal = req_funct3 <= 3'b010;
      else
         legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      misal = (req_funct3[1:0] == 2'b01 && req_addr[0])
            || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
   end

   always_comb begin
      last_q = 2'd3;
      unique case (f3_q[1:0])
         2'b00:   last_q = 2'd0;
         2'b01:   last_q = 2'd1;
         default: last_q = 2'd3;
      endcase
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               if (!legal || range_bad || (misal && !MISALIGN_SPLIT))
                  state_nx = ERR;
               else if (misal)
                  state_nx = SPLIT;
               else
                  state_nx = ACCESS;
            end
         end
         ACCESS:  state_nx = RESP;
         SPLIT:   if (idx_q == last_q) state_nx = RESP;
         RESP:    state_nx = IDLE;
         ERR:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign wbyte     = wdata_q[8*idx_q +: 8];
   assign req_ready = (state == IDLE);

   // Strobes are held low while rst is high so an abandoned split never
   // commits the byte that coincides with the reset edge.
   always_comb begin
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = 32'b0;
      mem_write_data = 32'b0;
      mem_funct3     = 3'b0;
      rsp_valid      = 1'b0;
      rsp_err        = 1'b0;
      rsp_rdata      = 32'b0;
      if (state == ACCESS && !rst) begin
         mem_read       = !we_q;
         mem_write      = we_q;
         mem_address    = addr_q;
         mem_funct3     = f3_q;
         mem_write_data = wdata_q;
      end else if (state == SPLIT && !rst) begin
         mem_read       = !we_q;
         mem_write      = we_q;
         mem_address    = addr_q + {30'b0, idx_q};
         mem_funct3     = we_q ? 3'b000 : 3'b100;
         mem_write_data = we_q ? {24'b0, wbyte} : 32'b0;
      end else if (state == RESP) begin
         rsp_valid = 1'b1;
         if (!we_q) begin
            unique case (f3_q)
               3'b000:  rsp_rdata = {{24{data_q[7]}}, data_q[7:0]};
               3'b001:  rsp_rdata = {{16{data_q[15]}}, data_q[15:0]};
               3'b100:  rsp_rdata = {24'b0, data_q[7:0]};
               3'b101:  rsp_rdata = {16'b0, data_q[15:0]};
               default: rsp_rdata = data_q;
            endcase
         end
      end else if (state == ERR) begin
         rsp_valid = 1'b1;
         rsp_err   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b0;
         addr_q  <= 32'b0;
         wdata_q <= 32'b0;
         data_q  <= 32'b0;
         idx_q   <= 2'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            data_q  <= 32'b0;
            idx_q   <= 2'b0;
         end else if (state == ACCESS) begin
            if (!we_q) data_q <= mem_read_data;
         end else if (state == SPLIT) begin
            idx_q <= idx_q + 2'd1;
            if (!we_q) data_q[8*idx_q +: 8] <= mem_read_data[7:0];
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte memory model, split and
// non-split instances, error, back-to-back and mid-split reset cases.
module tb_load_store_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, req_valid, req_we, sel;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;

   logic        rdy0, rv0, err0, mr0, mw0;
   logic [31:0] rd0, ma0, mwd0, mrd0;
   logic [2:0]  mf0;
   logic        rdy1, rv1, err1, mr1, mw1;
   logic [31:0] rd1, ma1, mwd1, mrd1;
   logic [2:0]  mf1;

   logic [7:0]  m [1024] = '{default: 8'h00};

   int n_vec = 0;
   int n_err = 0;

   load_store_unit #(.MEM_BYTES(1024), .MISALIGN_SPLIT(1'b1)) u0 (
      .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(rdy0),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0),
      .mem_read(mr0), .mem_write(mw0), .mem_address(ma0),
      .mem_write_data(mwd0), .mem_funct3(mf0), .mem_read_data(mrd0));

   load_store_unit #(.MEM_BYTES(1024), .MISALIGN_SPLIT(1'b0)) u1 (
      .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(rdy1),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(err1),
      .mem_read(mr1), .mem_write(mw1), .mem_address(ma1),
      .mem_write_data(mwd1), .mem_funct3(mf1), .mem_read_data(mrd1));

   function automatic logic [31:0] rdw(input logic [31:0] a);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = m[10'(a + 32'(i))];
      return r;
   endfunction

   always_comb mrd0 = rdw(ma0);
   always_comb mrd1 = rdw(ma1);

   always @(posedge clk) begin
      if (mw0) begin
         case (mf0[1:0])
            2'b00: m[ma0[9:0]] <= mwd0[7:0];
            2'b01: for (int i = 0; i < 2; i++) m[10'(ma0 + 32'(i))] <= mwd0[8*i +: 8];
            default: for (int i = 0; i < 4; i++) m[10'(ma0 + 32'(i))] <= mwd0[8*i +: 8];
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request, launched at a negedge; returns latency in cycles after accept.
   task automatic run(input logic s, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output logic [31:0] rdata,
                      output logic err, output int nrd, output int nwr);
      @(negedge clk);
      sel = s; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1; nrd = 0; nwr = 0;
      while (!(s ? rv1 : rv0) && lat < 20) begin
         nrd += int'(s ? mr1 : mr0);
         nwr += int'(s ? mw1 : mw0);
         @(negedge clk);
         lat++;
      end
      rdata = s ? rd1 : rd0;
      err   = s ? err1 : err0;
   endtask

   int          lat, nrd, nwr, pulses;
   logic [31:0] rdata;
   logic        err, seen;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; sel = 1'b0;
      req_funct3 = 3'b0; req_addr = 32'b0; req_wdata = 32'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", 32'(rdy0), 32'd1);
      chk("rst_rvalid", 32'(rv0), 32'd0);
      chk("rst_rdata", rd0, 32'd0);
      chk("rst_err", 32'(err0), 32'd0);
      chk("rst_mem", {mr0, mw0, mf0} | ma0 | mwd0, 32'd0);

      run(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rdata, err, nrd, nwr);
      chk("sw_lat", 32'(lat), 32'd2);
      chk("sw_nwr", 32'(nwr), 32'd1);
      chk("sw_err", 32'(err), 32'd0);
      chk("sw_mem", {m[19], m[18], m[17], m[16]}, 32'hDEADBEEF);
      run(0, 0, 3'b010, 32'h10, 32'h0, lat, rdata, err, nrd, nwr);
      chk("lw_lat", 32'(lat), 32'd2);
      chk("lw_nrd", 32'(nrd), 32'd1);
      chk("lw_data", rdata, 32'hDEADBEEF);
      chk("lw_err", 32'(err), 32'd0);

      run(0, 1, 3'b000, 32'h20, 32'h12345680, lat, rdata, err, nrd, nwr);
      chk("sb_mem", {m[33], m[32]}, 32'h0080);
      run(0, 0, 3'b000, 32'h20, 32'h0, lat, rdata, err, nrd, nwr);
      chk("lb_data", rdata, 32'hFFFFFF80);
      run(0, 0, 3'b100, 32'h20, 32'h0, lat, rdata, err, nrd, nwr);
      chk("lbu_data", rdata, 32'h00000080);
      run(0, 1, 3'b001, 32'h22, 32'hABCD9234, lat, rdata, err, nrd, nwr);
      chk("sh_mem", {m[37], m[36], m[35], m[34]}, 32'h00009234);
      run(0, 0, 3'b001, 32'h22, 32'h0, lat, rdata, err, nrd, nwr);
      chk("lh_data", rdata, 32'hFFFF9234);
      run(0, 0, 3'b101, 32'h22, 32'h0, lat, rdata, err, nrd, nwr);
      chk("lhu_data", rdata, 32'h00009234);

      run(0, 1, 3'b010, 32'h31, 32'h11223344, lat, rdata, err, nrd, nwr);
      chk("ssw_lat", 32'(lat), 32'd5);
      chk("ssw_nwr", 32'(nwr), 32'd4);
      chk("ssw_mem", {m[52], m[51], m[50], m[49]}, 32'h11223344);
      chk("ssw_nbr", {m[53], m[48]}, 32'h0);
      run(0, 0, 3'b010, 32'h31, 32'h0, lat, rdata, err, nrd, nwr);
      chk("slw_lat", 32'(lat), 32'd5);
      chk("slw_nrd", 32'(nrd), 32'd4);
      chk("slw_data", rdata, 32'h11223344);
      run(0, 0, 3'b001, 32'h33, 32'h0, lat, rdata, err, nrd, nwr);
      chk("slh_lat", 32'(lat), 32'd3);
      chk("slh_data", rdata, 32'h00001122);

      run(0, 0, 3'b001, 32'h3FF, 32'h0, lat, rdata, err, nrd, nwr);
      chk("oor_lh_err", 32'(err), 32'd1);
      chk("oor_lh_lat", 32'(lat), 32'd1);
      chk("oor_lh_data", rdata, 32'd0);
      run(0, 1, 3'b010, 32'h3FD, 32'h55555555, lat, rdata, err, nrd, nwr);
      chk("oor_sw_err", 32'(err), 32'd1);
      chk("oor_sw_lat", 32'(lat), 32'd1);
      chk("oor_sw_top", {m[1023], m[1022], m[1021]}, 32'd0);
      run(0, 0, 3'b011, 32'h10, 32'h0, lat, rdata, err, nrd, nwr);
      chk("ill_ld_err", 32'(err), 32'd1);
      run(0, 1, 3'b100, 32'h10, 32'h0, lat, rdata, err, nrd, nwr);
      chk("ill_st_err", 32'(err), 32'd1);
      chk("ill_st_mem", {m[19], m[18], m[17], m[16]}, 32'hDEADBEEF);
      run(0, 0, 3'b010, 32'h3FC, 32'h0, lat, rdata, err, nrd, nwr);
      chk("edge_lw_err", 32'(err), 32'd0);
      chk("edge_lw_lat", 32'(lat), 32'd2);

      run(1, 0, 3'b001, 32'h41, 32'h0, lat, rdata, err, nrd, nwr);
      chk("nosplit_err", 32'(err), 32'd1);
      chk("nosplit_nrd", 32'(nrd), 32'd0);
      run(1, 0, 3'b010, 32'h10, 32'h0, lat, rdata, err, nrd, nwr);
      chk("nosplit_lw", rdata, 32'hDEADBEEF);

      @(negedge clk);
      sel = 0; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h10;
      req_valid = 1'b1;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         pulses += int'(rv0);
      end
      req_valid = 1'b0;
      chk("b2b_pulses", 32'(pulses), 32'd2);

      @(negedge clk);
      sel = 0; req_we = 1; req_funct3 = 3'b010;
      req_addr = 32'h51; req_wdata = 32'hAABBCCDD;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      seen = rv0;
      @(negedge clk);
      seen |= rv0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen |= rv0;
      chk("rst_split_ready", 32'(rdy0), 32'd1);
      @(negedge clk);
      seen |= rv0;
      chk("rst_split_rsp", 32'(seen), 32'd0);
      chk("rst_split_b0", 32'(m[81]), 32'h000000DD);
      chk("rst_split_b1", {m[84], m[83], m[82]}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
